reg_file: RTL
=============

# reg_file

Parametrised multi-port register file, the word-wide, addressable successor to the single-bit storage latches. It provides DEPTH registers of WIDTH bits with one synchronous write port and two combinational read ports. An optional write-to-read bypass and an optional hard-wired zero register are included. It sits between the CPU decode stage (addresses) and the ALU operand inputs (read data), and the writeback stage drives its write port.

## Interface
Parameters:
- WIDTH, 16, bits per register
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
- clk  in  1  clock; all writes on rising edge
- clr  in  1  asynchronous, active-low reset; clears every register
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read address, port A
- raddr_b  in  AW  read address, port B
- rdata_a  out  WIDTH  read data, port A
- rdata_b  out  WIDTH  read data, port B

## Operation
- Storage: DEPTH x WIDTH flip-flops, no latches. No FSM; the state is the register array.
- Reset: clr falling clears all registers to 0 immediately, independent of clk. While clr is low, writes are ignored, bypass is disabled, and rdata_a and rdata_b are 0.
- Write: on a rising clk edge with clr high, we=1, and waddr < DEPTH, store wdata into register waddr. All other registers hold.
- Out-of-range write (waddr >= DEPTH): ignored, no register changes.
- ZERO_REG=1: writes to address 0 are ignored, and reads of address 0 return 0 (bypass never applies to address 0).
- Read: rdata_x = register[raddr_x] combinationally. Out-of-range raddr returns 0.
- Bypass (BYPASS=1): if clr is high, we=1, waddr==raddr_x, and the address is valid and writable, then rdata_x = wdata in the same cycle, before the edge.
- BYPASS=0: reads always show the pre-edge stored value.
- Both read ports are independent. Both may address the same register, and both bypass simultaneously when they match waddr.

## Timing
- Write latency: the value is visible on non-bypassed reads immediately after the capturing rising edge (0 cycles of read latency, 1 edge of write latency).
- Bypass path: purely combinational from wdata/we/waddr to rdata.
- Reset release: the first write can occur on the first rising edge at which clr is already high. Deasserting clr coincident with an edge must not corrupt registers; either outcome (write taken or not) is permitted only for that edge.
- Reset mid-operation: clr falling between edges clears everything, including a value written on the previous edge. A write attempted while clr is low is lost, not deferred.
- Output reset values: rdata_a = rdata_b = 0.

## Test plan
1. Reset: write 16'hFFFF to all registers, pulse clr low mid-cycle. Require all registers to read 0 without any clk edge and both rdata ports to be 0 while clr is low.
2. Write/read: write reg3=16'h1234 and reg5=16'hABCD on consecutive edges, then set raddr_a=3 and raddr_b=5. Require rdata_a=16'h1234 and rdata_b=16'hABCD. Other registers stay 0.
3. Bypass: with reg2 holding 16'h0001, drive we=1, waddr=2, wdata=16'h00FF, raddr_a=raddr_b=2. Require both ports to read 16'h00FF before the edge with BYPASS=1, and 16'h0001 before the edge then 16'h00FF after it with BYPASS=0.
4. ZERO_REG=1: write 16'hBEEF to address 0. Require reads of address 0 to return 0 both before and after the edge (no bypass).
5. Out-of-range with DEPTH=6: write 16'h5555 to address 7. Require no register to change and raddr_a=7 to return 0.
6. Write under reset: hold clr low, drive we=1, waddr=1, wdata=16'h7777, and clock 3 edges. Release clr and read address 1. Require the value 0.

Source files
------------

// File: rtl/reg_file.sv
// Multi-port register file with one synchronous write port and two combinational
// read ports. Optional same-cycle write forwarding and optional hard-wired zero register.
module reg_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  // DEPTH need not be a power of two, so the address range is checked explicitly.
  function automatic logic addr_valid(input logic [AW-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

  function automatic logic addr_live(input logic [AW-1:0] addr);
    return addr_valid(addr) && !(ZERO_REG && (addr == '0));
  endfunction

  assign wr_ok = clr && we && addr_live(waddr);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding reuses wr_ok, so reset, range and zero-register rules apply to it too.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (clr) begin
      if (addr_live(raddr_a)) rdata_a = regs[raddr_a];
      if (addr_live(raddr_b)) rdata_b = regs[raddr_b];
      if (BYPASS && wr_ok && (waddr == raddr_a)) rdata_a = wdata;
      if (BYPASS && wr_ok && (waddr == raddr_b)) rdata_b = wdata;
    end
  end

endmodule
